// File: rtl/uart_fifo_core_if.sv
// Host-side bus and serial lines of the UART FIFO core.
interface uart_fifo_core_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BAUD_WIDTH = 13
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  csn;
    logic                  wen;
    logic                  oen;
    logic [DATA_WIDTH-1:0] data_in;
    logic [BAUD_WIDTH-1:0] baud_val;
    logic                  parity_en;
    logic                  odd_n_even;
    logic                  two_stop;
    logic                  rx;
    logic                  tx;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  txrdy;
    logic                  rxrdy;
    logic                  parity_err;
    logic                  framing_err;
    logic                  overflow;
    logic [CNT_W-1:0]      tx_count;
    logic [CNT_W-1:0]      rx_count;

    modport master (
        output csn, wen, oen, data_in, baud_val, parity_en, odd_n_even, two_stop, rx,
        input  tx, data_out, txrdy, rxrdy, parity_err, framing_err, overflow,
               tx_count, rx_count
    );

    modport slave (
        input  csn, wen, oen, data_in, baud_val, parity_en, odd_n_even, two_stop, rx,
        output tx, data_out, txrdy, rxrdy, parity_err, framing_err, overflow,
               tx_count, rx_count
    );
endinterface

// File: rtl/uart_fifo_core.sv
// UART with TX/RX FIFOs, 16x oversampling baud generator and sticky RX error flags.
module uart_fifo_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BAUD_WIDTH = 13
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    uart_fifo_core_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ---------------- host strobes ----------------
    logic r_wr_act_d;
    logic r_rd_act_d;
    logic w_wr_act;
    logic w_rd_act;
    logic w_wr_evt;
    logic w_rd_evt;

    assign w_wr_act = ~bus.csn & ~bus.wen;
    assign w_rd_act = ~bus.csn & ~bus.oen;
    assign w_wr_evt = w_wr_act & ~r_wr_act_d;
    assign w_rd_evt = w_rd_act & ~r_rd_act_d;

    // Remember strobe level so a held strobe yields a single event.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr_act_d <= 1'b0;
            r_rd_act_d <= 1'b0;
        end else begin
            r_wr_act_d <= w_wr_act;
            r_rd_act_d <= w_rd_act;
        end
    end

    // ---------------- baud generator ----------------
    logic [BAUD_WIDTH-1:0] r_baud_cnt;
    logic                  w_tick;

    assign w_tick = (r_baud_cnt == '0);

    // Down-counter producing one oversample tick every BAUD_VAL+1 clocks.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_baud_cnt <= bus.baud_val;
        end else if (w_tick) begin
            r_baud_cnt <= bus.baud_val;
        end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_WIDTH'(1);
        end
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_tx_wp;
    logic [AW-1:0]         r_tx_rp;
    logic [CW-1:0]         r_tx_cnt;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic                  w_tx_pop;
    logic                  w_tx_push;
    logic [DATA_WIDTH-1:0] w_tx_head;

    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_push  = w_wr_evt & (~w_tx_full | w_tx_pop);
    assign w_tx_head  = r_tx_mem[r_tx_rp];

    // TX FIFO storage; contents are don't-care while empty.
    always_ff @(posedge i_clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wp] <= bus.data_in;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            unique case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    state_t                r_tx_state;
    logic [4:0]            r_tx_ticks;
    logic [BW-1:0]         r_tx_bits;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_tx_par;
    logic                  r_tx_par_en;
    logic                  r_tx_two_stop;
    logic                  r_tx;

    state_t                w_tx_state_nx;
    logic [4:0]            w_tx_ticks_nx;
    logic [BW-1:0]         w_tx_bits_nx;
    logic [DATA_WIDTH-1:0] w_tx_shift_nx;
    logic                  w_tx_par_nx;
    logic                  w_tx_par_en_nx;
    logic                  w_tx_two_stop_nx;
    logic                  w_tx_nx;
    logic                  w_tx_load;

    // TX next-state: frame sequencing, FIFO pop and line level.
    always_comb begin
        w_tx_state_nx    = r_tx_state;
        w_tx_ticks_nx    = r_tx_ticks;
        w_tx_bits_nx     = r_tx_bits;
        w_tx_shift_nx    = r_tx_shift;
        w_tx_par_nx      = r_tx_par;
        w_tx_par_en_nx   = r_tx_par_en;
        w_tx_two_stop_nx = r_tx_two_stop;
        w_tx_load        = 1'b0;
        w_tx_nx          = 1'b1;

        unique case (r_tx_state)
            ST_IDLE: begin
                if (w_tick && !w_tx_empty) w_tx_load = 1'b1;
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_tx_ticks == 5'd15) begin
                        w_tx_state_nx = ST_DATA;
                        w_tx_ticks_nx = '0;
                    end else begin
                        w_tx_ticks_nx = r_tx_ticks + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_tx_ticks == 5'd15) begin
                        w_tx_ticks_nx = '0;
                        w_tx_shift_nx = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
                        if (r_tx_bits == LAST_BIT) begin
                            w_tx_state_nx = r_tx_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            w_tx_bits_nx = r_tx_bits + BW'(1);
                        end
                    end else begin
                        w_tx_ticks_nx = r_tx_ticks + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    if (r_tx_ticks == 5'd15) begin
                        w_tx_state_nx = ST_STOP;
                        w_tx_ticks_nx = '0;
                    end else begin
                        w_tx_ticks_nx = r_tx_ticks + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_tx_ticks == (r_tx_two_stop ? 5'd31 : 5'd15)) begin
                        if (!w_tx_empty) begin
                            w_tx_load = 1'b1;
                        end else begin
                            w_tx_state_nx = ST_IDLE;
                            w_tx_ticks_nx = '0;
                        end
                    end else begin
                        w_tx_ticks_nx = r_tx_ticks + 5'd1;
                    end
                end
            end
            default: w_tx_state_nx = ST_IDLE;
        endcase

        // Frame start: pop head and freeze configuration for the whole frame.
        if (w_tx_load) begin
            w_tx_state_nx    = ST_START;
            w_tx_ticks_nx    = '0;
            w_tx_bits_nx     = '0;
            w_tx_shift_nx    = w_tx_head;
            w_tx_par_nx      = (^w_tx_head) ^ bus.odd_n_even;
            w_tx_par_en_nx   = bus.parity_en;
            w_tx_two_stop_nx = bus.two_stop;
        end

        unique case (w_tx_state_nx)
            ST_START:  w_tx_nx = 1'b0;
            ST_DATA:   w_tx_nx = w_tx_shift_nx[0];
            ST_PARITY: w_tx_nx = w_tx_par_nx;
            default:   w_tx_nx = 1'b1;
        endcase
    end

    assign w_tx_pop = w_tx_load;

    // TX state register and registered line output.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_tx_state    <= ST_IDLE;
            r_tx_ticks    <= '0;
            r_tx_bits     <= '0;
            r_tx_shift    <= '0;
            r_tx_par      <= 1'b0;
            r_tx_par_en   <= 1'b0;
            r_tx_two_stop <= 1'b0;
            r_tx          <= 1'b1;
        end else begin
            r_tx_state    <= w_tx_state_nx;
            r_tx_ticks    <= w_tx_ticks_nx;
            r_tx_bits     <= w_tx_bits_nx;
            r_tx_shift    <= w_tx_shift_nx;
            r_tx_par      <= w_tx_par_nx;
            r_tx_par_en   <= w_tx_par_en_nx;
            r_tx_two_stop <= w_tx_two_stop_nx;
            r_tx          <= w_tx_nx;
        end
    end

    // ---------------- RX synchroniser ----------------
    logic r_rx_s1;
    logic r_rx_s2;
    logic r_rx_prev;
    logic w_rx_fall;

    assign w_rx_fall = r_rx_prev & ~r_rx_s2;

    // Two-flop synchroniser plus one delayed copy for start-edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= bus.rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // ---------------- RX FSM ----------------
    state_t                r_rx_state;
    logic [3:0]            r_rx_ticks;
    logic [BW-1:0]         r_rx_bits;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic                  r_rx_par_en;
    logic                  r_rx_odd;
    logic                  r_rx_par_bit;

    state_t                w_rx_state_nx;
    logic [3:0]            w_rx_ticks_nx;
    logic [BW-1:0]         w_rx_bits_nx;
    logic [DATA_WIDTH-1:0] w_rx_shift_nx;
    logic                  w_rx_par_en_nx;
    logic                  w_rx_odd_nx;
    logic                  w_rx_par_bit_nx;
    logic                  w_rx_push;
    logic                  w_fe_set;
    logic                  w_pe_set;

    // RX next-state: mid-bit sampling and character completion.
    always_comb begin
        w_rx_state_nx   = r_rx_state;
        w_rx_ticks_nx   = r_rx_ticks;
        w_rx_bits_nx    = r_rx_bits;
        w_rx_shift_nx   = r_rx_shift;
        w_rx_par_en_nx  = r_rx_par_en;
        w_rx_odd_nx     = r_rx_odd;
        w_rx_par_bit_nx = r_rx_par_bit;
        w_rx_push       = 1'b0;
        w_fe_set        = 1'b0;
        w_pe_set        = 1'b0;

        unique case (r_rx_state)
            ST_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_state_nx  = ST_START;
                    w_rx_ticks_nx  = '0;
                    w_rx_par_en_nx = bus.parity_en;
                    w_rx_odd_nx    = bus.odd_n_even;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_rx_ticks == 4'd7) begin
                        w_rx_ticks_nx = '0;
                        w_rx_bits_nx  = '0;
                        w_rx_state_nx = r_rx_s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        w_rx_ticks_nx = r_rx_ticks + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_rx_ticks == 4'd15) begin
                        w_rx_ticks_nx = '0;
                        w_rx_shift_nx = {r_rx_s2, r_rx_shift[DATA_WIDTH-1:1]};
                        if (r_rx_bits == LAST_BIT) begin
                            w_rx_state_nx = r_rx_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            w_rx_bits_nx = r_rx_bits + BW'(1);
                        end
                    end else begin
                        w_rx_ticks_nx = r_rx_ticks + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    if (r_rx_ticks == 4'd15) begin
                        w_rx_ticks_nx   = '0;
                        w_rx_par_bit_nx = r_rx_s2;
                        w_rx_state_nx   = ST_STOP;
                    end else begin
                        w_rx_ticks_nx = r_rx_ticks + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_rx_ticks == 4'd15) begin
                        w_rx_ticks_nx = '0;
                        w_rx_state_nx = ST_IDLE;
                        w_rx_push     = 1'b1;
                        w_fe_set      = ~r_rx_s2;
                        w_pe_set      = r_rx_par_en &
                                        (r_rx_par_bit ^ (^r_rx_shift) ^ r_rx_odd);
                    end else begin
                        w_rx_ticks_nx = r_rx_ticks + 4'd1;
                    end
                end
            end
            default: w_rx_state_nx = ST_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rx_state   <= ST_IDLE;
            r_rx_ticks   <= '0;
            r_rx_bits    <= '0;
            r_rx_shift   <= '0;
            r_rx_par_en  <= 1'b0;
            r_rx_odd     <= 1'b0;
            r_rx_par_bit <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nx;
            r_rx_ticks   <= w_rx_ticks_nx;
            r_rx_bits    <= w_rx_bits_nx;
            r_rx_shift   <= w_rx_shift_nx;
            r_rx_par_en  <= w_rx_par_en_nx;
            r_rx_odd     <= w_rx_odd_nx;
            r_rx_par_bit <= w_rx_par_bit_nx;
        end
    end

    // ---------------- RX FIFO and flags ----------------
    logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_rx_wp;
    logic [AW-1:0]         r_rx_rp;
    logic [CW-1:0]         r_rx_cnt;
    logic                  r_parity_err;
    logic                  r_framing_err;
    logic                  r_overflow;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic                  w_rx_pop;
    logic                  w_rx_do_push;
    logic                  w_ovf_set;

    assign w_rx_full    = (r_rx_cnt == FULL_CNT);
    assign w_rx_empty   = (r_rx_cnt == '0);
    assign w_rx_pop     = w_rd_evt & ~w_rx_empty;
    assign w_rx_do_push = w_rx_push & (~w_rx_full | w_rx_pop);
    assign w_ovf_set    = w_rx_push & w_rx_full & ~w_rx_pop;

    // RX FIFO storage.
    always_ff @(posedge i_clk) begin
        if (w_rx_do_push) begin
            r_rx_mem[r_rx_wp] <= r_rx_shift;
        end
    end

    // RX FIFO pointers, occupancy and sticky error flags (set beats clear).
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rx_wp       <= '0;
            r_rx_rp       <= '0;
            r_rx_cnt      <= '0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_rx_do_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)     r_rx_rp <= r_rx_rp + AW'(1);
            unique case ({w_rx_do_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
            r_parity_err  <= w_pe_set  | (r_parity_err  & ~w_rd_evt);
            r_framing_err <= w_fe_set  | (r_framing_err & ~w_rd_evt);
            r_overflow    <= w_ovf_set | (r_overflow    & ~w_rd_evt);
        end
    end

    // ---------------- outputs ----------------
    assign bus.tx          = r_tx;
    assign bus.data_out    = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];
    assign bus.txrdy       = ~w_tx_full;
    assign bus.rxrdy       = ~w_rx_empty;
    assign bus.parity_err  = r_parity_err;
    assign bus.framing_err = r_framing_err;
    assign bus.overflow    = r_overflow;
    assign bus.tx_count    = r_tx_cnt;
    assign bus.rx_count    = r_rx_cnt;

endmodule
